// File: rtl/nios_multi_timer.sv
// nios_multi_timer: bank of NUM_CH independent down-counting interval timers behind an
// Avalon-MM slave. Each channel has four word registers addressed as {channel, reg[1:0]}:
//   0 STATUS  {RUN[1], TO[0]}            any write clears TO
//   1 CONTROL {PRE[15:8], STOP[3], START[2], CONT[1], ITO[0]}
//   2 PERIOD  reload value; a write also loads the counter and stops the channel
//   3 SNAP    a write captures the live counter, reads return the captured value
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   address         {channel, reg} word address
//   chipselect      slave select
//   write_n         active-low write strobe
//   writedata       write data
//   readdata        read data, registered every clock from address (1-cycle latency)
//   irq             per-channel interrupt, TO & ITO
//   irq_any         OR of irq
//
// Build option: define NIOS_MULTI_TIMER_PRESCALE_EN to add an 8-bit per-channel prescaler
// that ticks the counter every PRE+1 clocks. Without it the counters tick every clock and
// PRE reads as 0.
module nios_multi_timer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PERIOD_RST = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH-1:0]         irq,
  output logic                      irq_any
);

  localparam int unsigned AddrW = $clog2(NUM_CH) + 2;
  localparam int unsigned CselW = AddrW - 1;
  localparam logic [CNT_W-1:0] PeriodRst = PERIOD_RST[CNT_W-1:0];

  localparam logic [1:0] RegStatus  = 2'd0;
  localparam logic [1:0] RegControl = 2'd1;
  localparam logic [1:0] RegPeriod  = 2'd2;
  localparam logic [1:0] RegSnap    = 2'd3;

  // Zero-pad so the channel field is at least one bit wide even when NUM_CH == 1.
  logic [AddrW:0]   addr_ext;
  logic [CselW-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic             wr_en;
  logic [NUM_CH-1:0] hit;

  assign addr_ext = {1'b0, address};
  assign ch_sel   = addr_ext[AddrW:2];
  assign reg_sel  = addr_ext[1:0];
  assign wr_en    = chipselect && !write_n;

  always_comb begin
    hit = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      hit[n] = wr_en && (ch_sel == CselW'(n));
    end
  end

  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  snap_q [NUM_CH];
  logic [CNT_W-1:0]  snap_d [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] to_q, to_d;
  logic [NUM_CH-1:0] ito_q, ito_d;
  logic [NUM_CH-1:0] cont_q, cont_d;
  logic [NUM_CH-1:0] tick;
  logic [31:0]       rdata_d;

`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
  logic [7:0] pre_q [NUM_CH];
  logic [7:0] pre_d [NUM_CH];
  logic [7:0] psc_q [NUM_CH];
  logic [7:0] psc_d [NUM_CH];

  // >= rather than == so lowering PRE mid-run cannot strand the prescaler above it.
  always_comb begin
    tick = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      tick[n] = (psc_q[n] >= pre_q[n]);
    end
  end
`else
  assign tick = '1;
`endif

  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      count_d[n]  = count_q[n];
      period_d[n] = period_q[n];
      snap_d[n]   = snap_q[n];
      run_d[n]    = run_q[n];
      to_d[n]     = to_q[n];
      ito_d[n]    = ito_q[n];
      cont_d[n]   = cont_q[n];
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
      pre_d[n] = pre_q[n];
      psc_d[n] = psc_q[n];
      if (run_q[n]) begin
        psc_d[n] = tick[n] ? 8'd0 : psc_q[n] + 8'd1;
      end
`endif

      // Clear first so a timeout on the same edge re-sets TO below.
      if (hit[n] && (reg_sel == RegStatus)) begin
        to_d[n] = 1'b0;
      end

      if (run_q[n] && tick[n]) begin
        if (count_q[n] == '0) begin
          count_d[n] = period_q[n];
          to_d[n]    = 1'b1;
          if (!cont_q[n]) begin
            run_d[n] = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] - CNT_W'(1);
        end
      end

      // Register writes override the tick's effect on RUN and count.
      if (hit[n]) begin
        unique case (reg_sel)
          RegStatus: ;
          RegControl: begin
            ito_d[n]  = writedata[0];
            cont_d[n] = writedata[1];
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
            pre_d[n] = writedata[15:8];
            if (writedata[2]) begin
              psc_d[n] = 8'd0;
            end
`endif
            if (writedata[2]) begin
              run_d[n] = 1'b1;
            end else if (writedata[3]) begin
              run_d[n] = 1'b0;
            end
          end
          RegPeriod: begin
            period_d[n] = writedata[CNT_W-1:0];
            count_d[n]  = writedata[CNT_W-1:0];
            run_d[n]    = 1'b0;
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
            psc_d[n] = 8'd0;
`endif
          end
          RegSnap: snap_d[n] = count_q[n];
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (ch_sel == CselW'(n)) begin
        unique case (reg_sel)
          RegStatus: rdata_d[1:0] = {run_q[n], to_q[n]};
          RegControl: begin
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
            rdata_d[15:8] = pre_q[n];
`endif
            rdata_d[1:0] = {cont_q[n], ito_q[n]};
          end
          RegPeriod: rdata_d[CNT_W-1:0] = period_q[n];
          RegSnap:   rdata_d[CNT_W-1:0] = snap_q[n];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        count_q[n]  <= PeriodRst;
        period_q[n] <= PeriodRst;
        snap_q[n]   <= '0;
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
        pre_q[n] <= 8'd0;
        psc_q[n] <= 8'd0;
`endif
      end
      run_q    <= '0;
      to_q     <= '0;
      ito_q    <= '0;
      cont_q   <= '0;
      readdata <= '0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      snap_q   <= snap_d;
`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
      pre_q <= pre_d;
      psc_q <= psc_d;
`endif
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      readdata <= rdata_d;
    end
  end

  assign irq     = to_q & ito_q;
  assign irq_any = |irq;

  // Not every writedata bit maps to a register field.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Self-checking bench for nios_multi_timer (NUM_CH=4, CNT_W=32, PERIOD_RST=49999).
// Reset register table, directed multi-cycle sequences, then randomized register traffic
// compared against an event-based model that derives each channel's count/TO/RUN from the
// edge count elapsed since its last register write.
module tb_nios_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  irq;
  logic        irq_any;

  nios_multi_timer #(
    .NUM_CH    (4),
    .CNT_W     (32),
    .PERIOD_RST(49999)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_any   (irq_any)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

`ifdef NIOS_MULTI_TIMER_PRESCALE_EN
  localparam int PreDiv = 10;
  localparam logic [31:0] Ctl3Exp = 32'h0000_0403;
`else
  localparam int PreDiv = 2;
  localparam logic [31:0] Ctl3Exp = 32'h0000_0003;
`endif

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [3:0] a(input int ch, input int r);
    logic [3:0] v;
    v = {ch[1:0], r[1:0]};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] d);
    address = ad; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] ad, output logic [31:0] d);
    address = ad;
    step();
    d = readdata;
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by its state right after edge m_edge; later state follows
  // from how many ticks have elapsed since then.
  typedef struct {int cnt; bit run; bit to; bit tout;} st_t;
  int m_per[4], m_cnt[4], m_edge[4], m_snap[4];
  bit m_run[4], m_to[4], m_ito[4], m_cont[4];

  function automatic st_t m_state(input int ch, input int e);
    st_t s;
    int k, k1, ph;
    k = e - m_edge[ch];
    s.cnt = m_cnt[ch]; s.run = m_run[ch]; s.to = m_to[ch]; s.tout = 1'b0;
    if (m_run[ch] && k > 0) begin
      if (k <= m_cnt[ch]) begin
        s.cnt = m_cnt[ch] - k;
      end else begin
        k1 = m_cnt[ch] + 1;
        ph = (k - k1) % (m_per[ch] + 1);
        s.to = 1'b1;
        if (!m_cont[ch]) begin
          s.cnt = m_per[ch]; s.run = 1'b0; s.tout = (k == k1);
        end else begin
          s.cnt = m_per[ch] - ph; s.tout = (ph == 0);
        end
      end
    end
    return s;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_per[c] = 49999; m_cnt[c] = 49999; m_edge[c] = edge_cnt; m_snap[c] = 0;
      m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
    end
  endtask

  task automatic m_write(input int ch, input int r, input logic [31:0] wd, input int e);
    st_t s, p;
    s = m_state(ch, e);
    p = m_state(ch, e - 1);
    m_cnt[ch] = s.cnt; m_run[ch] = s.run; m_to[ch] = s.to; m_edge[ch] = e;
    case (r)
      0: m_to[ch] = s.tout;
      1: begin
        m_ito[ch] = wd[0]; m_cont[ch] = wd[1];
        if (wd[2]) m_run[ch] = 1'b1;
        else if (wd[3]) m_run[ch] = 1'b0;
      end
      2: begin m_per[ch] = int'(wd); m_cnt[ch] = int'(wd); m_run[ch] = 1'b0; end
      default: m_snap[ch] = p.cnt;
    endcase
  endtask

  function automatic logic [31:0] m_read(input int ch, input int r, input int e);
    st_t s;
    s = m_state(ch, e);
    case (r)
      0: return {30'd0, s.run, s.to};
      1: return {30'd0, m_cont[ch], m_ito[ch]};
      2: return m_per[ch];
      default: return m_snap[ch];
    endcase
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    step(); step();
    reset_n = 1'b1;
    m_reset();
  endtask

  typedef struct {logic [3:0] addr; logic [31:0] exp;} vec_t;
  vec_t vecs[16];

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      vecs[i].addr = 4'(i);
      vecs[i].exp  = ((i % 4) == 2) ? 32'd49999 : 32'd0;
    end

    do_reset();
    chk("reset_irq", {28'd0, irq}, 32'd0);
    chk("reset_irq_any", {31'd0, irq_any}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(vecs[i].addr, d);
      chk($sformatf("reset_reg_%0d", i), d, vecs[i].exp);
    end

    // Continuous ch0, PERIOD=3: timeout 4 clocks after START, then every 4.
    wr(a(0, 2), 32'd3);
    wr(a(0, 1), 32'h7);
    step(); step(); step();
    chk("ch0_irq_before", {31'd0, irq[0]}, 32'd0);
    step();
    chk("ch0_irq_first", {31'd0, irq[0]}, 32'd1);
    chk("ch0_irq_any", {31'd0, irq_any}, 32'd1);
    wr(a(0, 0), 32'd0);
    chk("ch0_clear", {31'd0, irq[0]}, 32'd0);
    step(); step();
    chk("ch0_irq_before2", {31'd0, irq[0]}, 32'd0);
    step();
    chk("ch0_irq_repeat", {31'd0, irq[0]}, 32'd1);
    // STATUS write on a reload edge: the timeout wins.
    step(); step(); step();
    wr(a(0, 0), 32'd0);
    chk("ch0_clear_vs_reload", {31'd0, irq[0]}, 32'd1);
    wr(a(0, 0), 32'd0);
    chk("ch0_clear_after", {31'd0, irq[0]}, 32'd0);
    wr(a(0, 1), 32'h8);

    // One-shot ch1, PERIOD=2.
    wr(a(1, 2), 32'd2);
    wr(a(1, 1), 32'h4);
    step(); step();
    rd(a(1, 0), d);
    chk("ch1_running", d, 32'h2);
    rd(a(1, 0), d);
    chk("ch1_oneshot_done", d, 32'h1);
    chk("ch1_no_irq", {28'd0, irq}, 32'd0);
    wr(a(1, 3), 32'd0);
    rd(a(1, 3), d);
    chk("ch1_count_holds", d, 32'd2);

    // START|STOP starts; PERIOD write while running stops and reloads.
    wr(a(1, 1), 32'hC);
    rd(a(1, 0), d);
    chk("ch1_start_wins", d, 32'h3);
    wr(a(1, 2), 32'd10);
    rd(a(1, 0), d);
    chk("ch1_period_stops", d, 32'h1);
    wr(a(1, 3), 32'd0);
    rd(a(1, 3), d);
    chk("ch1_period_reload", d, 32'd10);
    rd(a(1, 1), d);
    chk("ch1_ctl_readback", d, 32'd0);

    // Snapshot mid-count on ch2; ch3 must be untouched.
    wr(a(2, 2), 32'd100);
    wr(a(2, 1), 32'h6);
    repeat (9) step();
    wr(a(2, 3), 32'd0);
    rd(a(2, 3), d);
    chk("ch2_snap", d, 32'd91);
    rd(a(3, 3), d);
    chk("ch3_snap_untouched", d, 32'd0);
    rd(a(3, 2), d);
    chk("ch3_period_untouched", d, 32'd49999);
    rd(a(3, 0), d);
    chk("ch3_status_untouched", d, 32'd0);
    wr(a(2, 1), 32'h8);

    // Prescaler on ch3: PRE=4, PERIOD=1.
    wr(a(3, 2), 32'd1);
    wr(a(3, 1), 32'h407);
    repeat (PreDiv - 1) step();
    chk("ch3_pre_before", {31'd0, irq[3]}, 32'd0);
    step();
    chk("ch3_pre_first", {31'd0, irq[3]}, 32'd1);
    wr(a(3, 0), 32'd0);
    chk("ch3_pre_clear", {31'd0, irq[3]}, 32'd0);
    repeat (PreDiv - 2) step();
    chk("ch3_pre_before2", {31'd0, irq[3]}, 32'd0);
    step();
    chk("ch3_pre_second", {31'd0, irq[3]}, 32'd1);
    rd(a(3, 1), d);
    chk("ch3_ctl_pre", d, Ctl3Exp);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int ch, r, e;
      bit is_wr;
      logic [31:0] wd, exp_rd;
      logic [3:0] exp_irq;
      st_t s;
      ch = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      is_wr = 1'($urandom_range(0, 1));
      case (r)
        1: wd = 32'($urandom_range(0, 15));
        2: wd = 32'($urandom_range(0, 7));
        default: wd = $urandom;
      endcase
      address = a(ch, r);
      writedata = wd;
      chipselect = is_wr ? 1'b1 : 1'($urandom_range(0, 1));
      write_n = !is_wr;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      e = edge_cnt;
      exp_rd = m_read(ch, r, e - 1);
      if (is_wr) m_write(ch, r, wd, e);
      chk($sformatf("rand_rd_%0d", it), readdata, exp_rd);
      for (int c = 0; c < 4; c++) begin
        s = m_state(c, e);
        exp_irq[c] = s.to & m_ito[c];
      end
      chk($sformatf("rand_irq_%0d", it), {27'd0, irq_any, irq}, {27'd0, |exp_irq, exp_irq});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nios_multi_timer.md
NIOS_MULTI_TIMER -- requirements
Module: nios_multi_timer

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent timer channels (legal: 1, 2, 4, 8).
REQ-002 SHALL provide parameter CNT_W, default 32, counter/period width in bits (legal 8..32).
REQ-003 SHALL provide parameter PERIOD_RST, default 49999, reset value of every channel's period and counter (truncated to CNT_W).
REQ-004 SHALL provide port clk, input, 1, clock.
REQ-005 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port address, input, log2(NUM_CH)+2, {channel, reg[1:0]} word address.
REQ-007 SHALL provide port chipselect, input, 1, Avalon slave select.
REQ-008 SHALL provide port write_n, input, 1, active-low write strobe.
REQ-009 SHALL provide port writedata, input, 32, write data.
REQ-010 SHALL provide port readdata, output, 32, registered read data.
REQ-011 SHALL provide port irq, output, NUM_CH, per-channel interrupt.
REQ-012 SHALL provide port irq_any, output, 1, OR of irq bits.

Function
REQ-013 SHALL decode per-channel registers: reg 0 STATUS {RUN[1], TO[0]}; reg 1 CONTROL {PRE[15:8], STOP[3], START[2], CONT[1], ITO[0]}; reg 2 PERIOD[CNT_W-1:0]; reg 3 SNAP[CNT_W-1:0].
REQ-014 SHALL register readdata every clock from the current address (1-cycle read latency), zero-extending unused upper bits; CONTROL reads return STOP/START as 0.
REQ-015 SHALL define write = chipselect && !write_n; all register effects apply at the next clk edge.
REQ-016 SHALL, on a channel tick while RUN=1: if count==0, load count<=PERIOD and set TO; else count<=count-1.
REQ-017 SHALL clear RUN on the same edge count reloads from zero when CONT=0 (one-shot); with CONT=1, RUN stays set.
REQ-018 SHALL, on a CONTROL write, store ITO, CONT, PRE; set RUN if START=1; else clear RUN if STOP=1 (START wins when both set).
REQ-019 SHALL, on a PERIOD write, store PERIOD, load count<=new PERIOD on the same edge, and clear RUN.
REQ-020 SHALL, on any STATUS write, clear TO; a timeout on the same edge SHALL win (TO stays 1).
REQ-021 SHALL, on any SNAP write, capture the channel's current count into SNAP; reads return the captured value.
REQ-022 SHALL drive irq[n] = TO[n] && ITO[n] combinationally from registers; irq_any = |irq.
REQ-023 SHALL keep channels fully independent; an access to one channel SHALL not affect others.
REQ-024 SHALL wrap only via reload; count SHALL never underflow below 0.

Reset
REQ-025 SHALL on reset_n=0 asynchronously set count=PERIOD=PERIOD_RST, RUN=0, TO=0, ITO=0, CONT=0, PRE=0, SNAP=0, readdata=0, prescale counters=0.
REQ-026 SHALL resume counting only after an explicit START write following reset.

Configuration
REQ-027 SHALL, with macro NIOS_MULTI_TIMER_PRESCALE_EN defined, generate a tick every PRE+1 clocks per channel via an 8-bit prescale counter cleared on START and PERIOD writes.
REQ-028 SHALL, without NIOS_MULTI_TIMER_PRESCALE_EN, tick every clock, omit the prescale counters, and read PRE as 0.

Verification
REQ-029 SHALL verify: reset; ch0 PERIOD=3, CONTROL=0x7 (START|CONT|ITO) -> TO/irq[0] first asserts 4 clocks after start, repeats every 4 clocks; irq_any high.
REQ-030 SHALL verify: ch1 PERIOD=2, CONTROL=0x4 (one-shot) -> TO=1 after 3 ticks, RUN=0, count holds 2.
REQ-031 SHALL verify: STATUS write coinciding with reload edge -> TO remains 1; next STATUS write -> TO=0, irq deasserts next cycle.
REQ-032 SHALL verify: CONTROL=0xC (START|STOP) -> RUN=1; PERIOD write while running -> RUN=0, count=new PERIOD.
REQ-033 SHALL verify: with PRESCALE_EN, PRE=4, PERIOD=1 -> timeout every 10 clocks; without macro, same writes -> every 2 clocks.
REQ-034 SHALL verify: SNAP write on ch2 mid-count -> SNAP read (1-cycle latency) equals count at write edge; ch3 unaffected.
